// File: rtl/rriot_bus_arbiter.sv
// rriot_bus_arbiter
// Shares one mcs6530 RRIOT bus between the 6502 CPU port and an aux port
// (debug loader / monitor DMA). One requester is granted per phi2 cycle; the
// CPU has priority, and aux is protected from starvation by a defer counter.
// Aux may also lock bursts, with one forced release cycle after MAX_BURST grants.
// Read data is returned to the owner one cycle after the access.
//
// owner state | meaning
// ------------+-----------------------------------------------
// OWN_NONE    | no access performed last cycle
// OWN_CPU     | CPU accessed the RRIOT last cycle
// OWN_AUX     | aux accessed the RRIOT last cycle
module rriot_bus_arbiter #(
    parameter int unsigned MAX_DEFER = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       phi2,
    input  logic       rst_n,
    // CPU port
    input  logic       cpu_req,
    input  logic       cpu_we_n,
    input  logic [9:0] cpu_a,
    input  logic       cpu_rs0,
    input  logic       cpu_cs1,
    input  logic [7:0] cpu_di,
    output logic       cpu_rdy,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_do,
    // aux port
    input  logic       aux_req,
    input  logic       aux_lock,
    input  logic       aux_we_n,
    input  logic [9:0] aux_a,
    input  logic       aux_rs0,
    input  logic       aux_cs1,
    input  logic [7:0] aux_di,
    output logic       aux_gnt,
    output logic       aux_rvalid,
    output logic [7:0] aux_do,
    // RRIOT bus
    output logic       rriot_we_n,
    output logic [9:0] rriot_a,
    output logic       rriot_rs0,
    output logic       rriot_cs1,
    output logic [7:0] rriot_di,
    input  logic [7:0] rriot_do,
    input  logic       rriot_oe
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_DEFER_C = 4'(MAX_DEFER);
    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    owner_t     r_owner;
    logic [3:0] r_defer_cnt;
    logic [3:0] r_burst_cnt;
    logic       r_cpu_rvalid;
    logic       r_aux_rvalid;
    logic [7:0] r_cpu_do_hold;
    logic [7:0] r_aux_do_hold;

    owner_t     w_grant;
    logic       w_release;
    logic       w_aux_gnt;
    logic [7:0] w_rd_data;

    // Pick this cycle's bus owner; nothing is granted while reset is asserted
    // so the bus drops to its idle value immediately.
    always_comb begin
        w_release = aux_req && aux_lock && (r_burst_cnt == MAX_BURST_C);
        w_grant   = OWN_NONE;
        if (!rst_n) begin
            w_grant = OWN_NONE;
        end else if (w_release) begin
            // aux sits out one cycle after a full burst; the CPU may use it
            w_grant = cpu_req ? OWN_CPU : OWN_NONE;
        end else if (cpu_req && aux_req) begin
            if ((r_defer_cnt == MAX_DEFER_C) ||
                ((r_owner == OWN_AUX) && aux_lock && (r_burst_cnt < MAX_BURST_C)))
                w_grant = OWN_AUX;
            else
                w_grant = OWN_CPU;
        end else if (cpu_req) begin
            w_grant = OWN_CPU;
        end else if (aux_req) begin
            w_grant = OWN_AUX;
        end
    end

    assign w_aux_gnt = (w_grant == OWN_AUX);
    assign aux_gnt   = w_aux_gnt;
    assign cpu_rdy   = !(cpu_req && w_aux_gnt);

    // Drive the granted requester's fields, or an idle bus that decodes no region.
    always_comb begin
        rriot_we_n = 1'b1;
        rriot_a    = 10'd0;
        rriot_rs0  = 1'b0;
        rriot_cs1  = 1'b0;
        rriot_di   = 8'd0;
        case (w_grant)
            OWN_CPU: begin
                rriot_we_n = cpu_we_n;
                rriot_a    = cpu_a;
                rriot_rs0  = cpu_rs0;
                rriot_cs1  = cpu_cs1;
                rriot_di   = cpu_di;
            end
            OWN_AUX: begin
                rriot_we_n = aux_we_n;
                rriot_a    = aux_a;
                rriot_rs0  = aux_rs0;
                rriot_cs1  = aux_cs1;
                rriot_di   = aux_di;
            end
            default: ;
        endcase
    end

    // Undriven RRIOT data bus reads as open bus.
    assign w_rd_data = rriot_oe ? rriot_do : 8'hFF;

    // Read data is live in the response cycle, then held until the next read.
    assign cpu_rvalid = r_cpu_rvalid;
    assign aux_rvalid = r_aux_rvalid;
    assign cpu_do     = r_cpu_rvalid ? w_rd_data : r_cpu_do_hold;
    assign aux_do     = r_aux_rvalid ? w_rd_data : r_aux_do_hold;

    // Owner tracking, fairness counters and read-response bookkeeping.
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_owner       <= OWN_NONE;
            r_defer_cnt   <= 4'd0;
            r_burst_cnt   <= 4'd0;
            r_cpu_rvalid  <= 1'b0;
            r_aux_rvalid  <= 1'b0;
            r_cpu_do_hold <= 8'h00;
            r_aux_do_hold <= 8'h00;
        end else begin
            r_owner <= w_grant;

            if (aux_req && !w_aux_gnt)
                r_defer_cnt <= (r_defer_cnt == MAX_DEFER_C) ? r_defer_cnt
                                                            : r_defer_cnt + 4'd1;
            else
                r_defer_cnt <= 4'd0;

            if (w_aux_gnt && aux_lock)
                r_burst_cnt <= r_burst_cnt + 4'd1;
            else
                r_burst_cnt <= 4'd0;

            r_cpu_rvalid <= (w_grant == OWN_CPU) && cpu_we_n;
            r_aux_rvalid <= (w_grant == OWN_AUX) && aux_we_n;

            if (r_cpu_rvalid)
                r_cpu_do_hold <= w_rd_data;
            if (r_aux_rvalid)
                r_aux_do_hold <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// Self-checking bench for rriot_bus_arbiter: a cycle model predicts the grant
// and bus each cycle, and a scoreboard queue carries expected read responses
// from the access cycle to the response cycle.
module tb_rriot_bus_arbiter;

    localparam int MAX_DEFER = 4;
    localparam int MAX_BURST = 8;

    logic       phi2;
    logic       rst_n;
    logic       cpu_req, cpu_we_n, cpu_rs0, cpu_cs1;
    logic [9:0] cpu_a;
    logic [7:0] cpu_di;
    logic       cpu_rdy, cpu_rvalid;
    logic [7:0] cpu_do;
    logic       aux_req, aux_lock, aux_we_n, aux_rs0, aux_cs1;
    logic [9:0] aux_a;
    logic [7:0] aux_di;
    logic       aux_gnt, aux_rvalid;
    logic [7:0] aux_do;
    logic       rriot_we_n, rriot_rs0, rriot_cs1;
    logic [9:0] rriot_a;
    logic [7:0] rriot_di;
    logic [7:0] rriot_do;
    logic       rriot_oe;

    rriot_bus_arbiter #(.MAX_DEFER(MAX_DEFER), .MAX_BURST(MAX_BURST)) dut (
        .phi2(phi2), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we_n(cpu_we_n), .cpu_a(cpu_a), .cpu_rs0(cpu_rs0),
        .cpu_cs1(cpu_cs1), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .cpu_rvalid(cpu_rvalid),
        .cpu_do(cpu_do),
        .aux_req(aux_req), .aux_lock(aux_lock), .aux_we_n(aux_we_n), .aux_a(aux_a),
        .aux_rs0(aux_rs0), .aux_cs1(aux_cs1), .aux_di(aux_di), .aux_gnt(aux_gnt),
        .aux_rvalid(aux_rvalid), .aux_do(aux_do),
        .rriot_we_n(rriot_we_n), .rriot_a(rriot_a), .rriot_rs0(rriot_rs0),
        .rriot_cs1(rriot_cs1), .rriot_di(rriot_di), .rriot_do(rriot_do),
        .rriot_oe(rriot_oe)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    typedef struct {
        bit is_aux;
    } rsp_t;

    rsp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         m_owner;      // 0 none, 1 cpu, 2 aux
    int         m_defer;
    int         m_burst;
    logic [7:0] m_cpu_hold;
    logic [7:0] m_aux_hold;
    logic       last_aux_gnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we_n, input logic [9:0] a,
                           input logic rs0, input logic cs1, input logic [7:0] di);
        cpu_req = req; cpu_we_n = we_n; cpu_a = a; cpu_rs0 = rs0; cpu_cs1 = cs1; cpu_di = di;
    endtask

    task automatic set_aux(input logic req, input logic lock, input logic we_n,
                           input logic [9:0] a, input logic rs0, input logic cs1,
                           input logic [7:0] di);
        aux_req = req; aux_lock = lock; aux_we_n = we_n; aux_a = a;
        aux_rs0 = rs0; aux_cs1 = cs1; aux_di = di;
    endtask

    task automatic model_reset();
        sb.delete();
        m_owner = 0; m_defer = 0; m_burst = 0;
        m_cpu_hold = 8'h00; m_aux_hold = 8'h00;
    endtask

    // Inputs are set by the caller near the falling edge; one call is one phi2 cycle.
    task automatic step();
        int         g;
        bit         rel;
        bit         exp_cv, exp_av;
        logic [7:0] rd;
        logic [20:0] exp_bus;
        rsp_t       e;
        #1;
        rd = rriot_oe ? rriot_do : 8'hFF;
        exp_cv = 0; exp_av = 0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_aux) exp_av = 1; else exp_cv = 1;
        end
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
        check("aux_rvalid", 32'(aux_rvalid), 32'(exp_av));
        check("cpu_do", 32'(cpu_do), 32'(exp_cv ? rd : m_cpu_hold));
        check("aux_do", 32'(aux_do), 32'(exp_av ? rd : m_aux_hold));
        if (exp_cv) m_cpu_hold = rd;
        if (exp_av) m_aux_hold = rd;

        rel = aux_req && aux_lock && (m_burst == MAX_BURST);
        if (rel)                      g = cpu_req ? 1 : 0;
        else if (cpu_req && aux_req)  g = ((m_defer == MAX_DEFER) ||
                                           (m_owner == 2 && aux_lock && m_burst < MAX_BURST)) ? 2 : 1;
        else if (cpu_req)             g = 1;
        else if (aux_req)             g = 2;
        else                          g = 0;

        check("aux_gnt", 32'(aux_gnt), 32'(g == 2));
        check("cpu_rdy", 32'(cpu_rdy), 32'(!(cpu_req && g == 2)));
        if (g == 1)      exp_bus = {cpu_we_n, cpu_a, cpu_rs0, cpu_cs1, cpu_di};
        else if (g == 2) exp_bus = {aux_we_n, aux_a, aux_rs0, aux_cs1, aux_di};
        else             exp_bus = {1'b1, 10'd0, 1'b0, 1'b0, 8'd0};
        check("rriot_bus", 32'({rriot_we_n, rriot_a, rriot_rs0, rriot_cs1, rriot_di}),
              32'(exp_bus));
        last_aux_gnt = aux_gnt;
        if (g == 1 && cpu_we_n) sb.push_back('{is_aux: 1'b0});
        if (g == 2 && aux_we_n) sb.push_back('{is_aux: 1'b1});

        @(posedge phi2);
        if (aux_req && g != 2) m_defer = (m_defer == MAX_DEFER) ? m_defer : m_defer + 1;
        else                   m_defer = 0;
        if (g == 2 && aux_lock) m_burst = m_burst + 1;
        else                    m_burst = 0;
        m_owner = g;
        @(negedge phi2);
    endtask

    task automatic idle();
        set_cpu(0, 1, 10'd0, 0, 0, 8'd0);
        set_aux(0, 0, 1, 10'd0, 0, 0, 8'd0);
    endtask

    logic [11:0] pat;

    initial begin
        rst_n = 1'b0;
        idle();
        rriot_do = 8'h00; rriot_oe = 1'b1;
        last_aux_gnt = 1'b0;
        model_reset();
        repeat (2) @(posedge phi2);
        #1;
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_cpu_do", 32'(cpu_do), 32'h00);
        check("rst_aux_do", 32'(aux_do), 32'h00);
        @(negedge phi2);
        rst_n = 1'b1;

        // CPU read of ROM, data returned next cycle and held afterwards
        rriot_do = 8'h5A; rriot_oe = 1'b1;
        set_cpu(1, 1, 10'h380, 1, 0, 8'h00);
        step();
        idle();
        step();
        check("t1_cpu_do", 32'(cpu_do), 32'h5A);
        rriot_do = 8'h33;
        step();

        // both requesting: 4 CPU grants, then aux forced ahead
        pat = '0;
        set_cpu(1, 0, 10'h011, 0, 1, 8'hA1);
        set_aux(1, 0, 0, 10'h022, 0, 1, 8'hB2);
        for (int i = 0; i < 5; i++) begin
            step();
            pat[i] = last_aux_gnt;
        end
        check("t2_pattern", 32'(pat[4:0]), 32'h10);
        idle();
        step();

        // locked aux burst with idle CPU: 8 grants, one release gap, resume
        pat = '0;
        set_aux(1, 1, 0, 10'h100, 0, 1, 8'h00);
        for (int i = 0; i < 12; i++) begin
            aux_di = 8'(i);
            step();
            pat[i] = last_aux_gnt;
        end
        check("t3_pattern", 32'(pat), 32'hEFF);
        idle();
        step();

        // aux read with RRIOT not driving: open-bus data
        rriot_oe = 1'b0;
        set_aux(1, 0, 1, 10'h200, 0, 1, 8'h00);
        step();
        idle();
        step();
        check("t4_aux_do", 32'(aux_do), 32'hFF);
        rriot_oe = 1'b1; rriot_do = 8'hC3;
        step();

        // alternating CPU/aux writes, no lock
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i % 2 == 0) set_cpu(1, 0, 10'(i * 17), 1, 1, 8'(i + 8'h40));
            else            set_aux(1, 0, 0, 10'(i * 29), 0, 1, 8'(i + 8'h80));
            step();
        end
        idle();
        step();

        // reset in the middle of a read response
        rriot_do = 8'h77;
        set_cpu(1, 1, 10'h3F0, 0, 1, 8'h00);
        step();
        check("t5_pre_rvalid", 32'(cpu_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rvalid", 32'(cpu_rvalid), 32'd0);
        check("t5_we_n", 32'(rriot_we_n), 32'd1);
        check("t5_cs1", 32'(rriot_cs1), 32'd0);
        check("t5_cpu_do", 32'(cpu_do), 32'h00);
        model_reset();
        @(posedge phi2);
        @(negedge phi2);
        rst_n = 1'b1;

        // simultaneous requests right after reset: CPU wins
        set_cpu(1, 1, 10'h005, 0, 1, 8'h00);
        set_aux(1, 0, 1, 10'h006, 0, 1, 8'h00);
        step();
        check("t5_cpu_first", 32'(last_aux_gnt), 32'd0);
        idle();
        step();

        // random mix against the model
        for (int i = 0; i < 300; i++) begin
            set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    10'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom));
            set_aux(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom));
            rriot_do = 8'($urandom);
            rriot_oe = 1'($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
